multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the RV32 subset datapath (FD). It sequences IDLE/FETCH/DECODE/EXECUTE/MEM/WRITE_BACK/TRAP and supports configurable memory wait states. It decodes opcode/funct3/funct7[5] into datapath enables, mux selects and ALU command. It adds I-type ALU, BNE, JAL and illegal-opcode trapping to the existing R/LOAD/STORE/BEQ set.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RV32 subset datapath: sequences fetch/decode/execute/mem/write-back
// with configurable memory wait states and decodes the latched instruction fields into datapath controls.
module multicycle_ctrl #(
  parameter int MEM_WAIT  = 0,
  parameter int ALU_CMD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic [3:0]           alu_flags,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 alu_src,
  output logic [1:0]           rf_src,
  output logic                 rf_we,
  output logic                 d_mem_we,
  output logic                 d_mem_re,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic [2:0]           state,
  output logic                 illegal
);

  // state      | meaning
  // S_IDLE     | one cycle after reset before the first fetch
  // S_FETCH    | instruction memory access, MEM_WAIT+1 cycles
  // S_DECODE   | latch opcode/funct fields, trap on unknown opcode
  // S_EXECUTE  | ALU operation, branch condition captured
  // S_MEM      | data memory access, MEM_WAIT+1 cycles
  // S_WB       | PC and register file update
  // S_TRAP     | illegal opcode, held until reset
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_AND = 3'd2;
  localparam logic [2:0] CMD_OR  = 3'd3;
  localparam logic [2:0] CMD_XOR = 3'd4;
  localparam logic [2:0] CMD_SLT = 3'd5;

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f7_q;
  logic       taken_q;
  logic [2:0] cmd;
  logic       unused_flags;

  assign unused_flags = ^alu_flags[3:1];

  function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_map = sub_en ? CMD_SUB : CMD_ADD;
      3'b111:  alu_map = CMD_AND;
      3'b110:  alu_map = CMD_OR;
      3'b100:  alu_map = CMD_XOR;
      3'b010:  alu_map = CMD_SLT;
      default: alu_map = CMD_ADD;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    op_legal = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BR) || (op == OP_JAL);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        f7_q <= funct7b5;
      end
      if (state_q == S_EXECUTE) begin
        taken_q <= (op_q == OP_BR) &&
                   (((f3_q == 3'b000) && alu_flags[0]) ||
                    ((f3_q == 3'b001) && !alu_flags[0]));
      end
    end
  end

  // Next state; the wait counter only advances while a memory phase is still in progress.
  always_comb begin
    state_d = state_q;
    wait_d  = 3'd0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (wait_q == WAIT_LAST) state_d = S_DECODE;
        else                     wait_d  = wait_q + 3'd1;
      end
      S_DECODE: state_d = op_legal(opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if ((op_q == OP_LOAD) || (op_q == OP_STORE)) state_d = S_MEM;
        else                                         state_d = S_WB;
      end
      S_MEM: begin
        if (wait_q == WAIT_LAST) state_d = S_WB;
        else                     wait_d  = wait_q + 3'd1;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    alu_src  = 1'b0;
    rf_src   = 2'd0;
    rf_we    = 1'b0;
    d_mem_we = 1'b0;
    d_mem_re = 1'b0;
    illegal  = 1'b0;
    cmd      = CMD_ADD;
    case (state_q)
      S_FETCH: ir_we = (wait_q == WAIT_LAST);
      S_EXECUTE: begin
        case (op_q)
          OP_R:                     cmd = alu_map(f3_q, f7_q);
          OP_I: begin
            cmd     = alu_map(f3_q, 1'b0);
            alu_src = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JAL: alu_src = 1'b1;
          OP_BR:                    cmd = CMD_SUB;
          default:                  cmd = CMD_ADD;
        endcase
      end
      S_MEM: begin
        alu_src  = 1'b1;
        d_mem_re = (op_q == OP_LOAD);
        d_mem_we = (op_q == OP_STORE) && (wait_q == WAIT_LAST);
      end
      S_WB: begin
        pc_we = 1'b1;
        if (op_q == OP_JAL)  pc_src = 2'd2;
        else if (taken_q)    pc_src = 2'd1;
        rf_we = (op_q == OP_R) || (op_q == OP_I) || (op_q == OP_LOAD) || (op_q == OP_JAL);
        if (op_q == OP_LOAD)     rf_src = 2'd1;
        else if (op_q == OP_JAL) rf_src = 2'd2;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign alu_cmd = {{(ALU_CMD_W-3){1'b0}}, cmd};
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_WAIT=0 and 2) driven from one stimulus stream, each
// checked cycle by cycle against an instruction-level trace model built from the control rules.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] rf_src;
    logic       rf_we;
    logic       d_mem_we;
    logic       d_mem_re;
    logic [3:0] alu_cmd;
    logic       illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic [3:0] alu_flags = 4'd0;
  int         sel = 0;

  logic       ir_we_a[2], pc_we_a[2], alu_src_a[2], rf_we_a[2];
  logic       d_mem_we_a[2], d_mem_re_a[2], illegal_a[2];
  logic [1:0] pc_src_a[2], rf_src_a[2];
  logic [3:0] alu_cmd_a[2];
  logic [2:0] state_a[2];
  vec_t       obs;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT(0), .ALU_CMD_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_flags(alu_flags), .ir_we(ir_we_a[0]), .pc_we(pc_we_a[0]), .pc_src(pc_src_a[0]),
    .alu_src(alu_src_a[0]), .rf_src(rf_src_a[0]), .rf_we(rf_we_a[0]), .d_mem_we(d_mem_we_a[0]),
    .d_mem_re(d_mem_re_a[0]), .alu_cmd(alu_cmd_a[0]), .state(state_a[0]), .illegal(illegal_a[0]));

  multicycle_ctrl #(.MEM_WAIT(2), .ALU_CMD_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_flags(alu_flags), .ir_we(ir_we_a[1]), .pc_we(pc_we_a[1]), .pc_src(pc_src_a[1]),
    .alu_src(alu_src_a[1]), .rf_src(rf_src_a[1]), .rf_we(rf_we_a[1]), .d_mem_we(d_mem_we_a[1]),
    .d_mem_re(d_mem_re_a[1]), .alu_cmd(alu_cmd_a[1]), .state(state_a[1]), .illegal(illegal_a[1]));

  always_comb begin
    obs = '{st: state_a[sel], ir_we: ir_we_a[sel], pc_we: pc_we_a[sel], pc_src: pc_src_a[sel],
            alu_src: alu_src_a[sel], rf_src: rf_src_a[sel], rf_we: rf_we_a[sel],
            d_mem_we: d_mem_we_a[sel], d_mem_re: d_mem_re_a[sel], alu_cmd: alu_cmd_a[sel],
            illegal: illegal_a[sel]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic allow_sub);
    case (f3)
      3'b000:  return allow_sub ? 4'd1 : 4'd0;
      3'b111:  return 4'd2;
      3'b110:  return 4'd3;
      3'b100:  return 4'd4;
      3'b010:  return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // Expected per-cycle trace of one instruction, from FETCH through WRITE_BACK (or TRAP cycles).
  task automatic build(input int w, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [3:0] flags, input int ntrap);
    vec_t e;
    bit is_r, is_i, is_ld, is_st, is_br, is_jal, taken;
    is_r   = (op == 7'b0110011);
    is_i   = (op == 7'b0010011);
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_br  = (op == 7'b1100011);
    is_jal = (op == 7'b1101111);
    taken  = is_br && ((f3 == 3'b000 && flags[0]) || (f3 == 3'b001 && !flags[0]));
    exp_q.delete();
    for (int i = 0; i <= w; i++) begin
      e = '0; e.st = 3'd1; e.ir_we = (i == w); exp_q.push_back(e);
    end
    e = '0; e.st = 3'd2; exp_q.push_back(e);
    if (!(is_r || is_i || is_ld || is_st || is_br || is_jal)) begin
      for (int i = 0; i < ntrap; i++) begin
        e = '0; e.st = 3'd6; e.illegal = 1'b1; exp_q.push_back(e);
      end
      return;
    end
    e = '0; e.st = 3'd3;
    if (is_r)  e.alu_cmd = alu_ref(f3, f7);
    if (is_i)  e.alu_cmd = alu_ref(f3, 1'b0);
    if (is_br) e.alu_cmd = 4'd1;
    e.alu_src = is_i || is_ld || is_st || is_jal;
    exp_q.push_back(e);
    if (is_ld || is_st) begin
      for (int i = 0; i <= w; i++) begin
        e = '0; e.st = 3'd4; e.alu_src = 1'b1;
        e.d_mem_re = is_ld;
        e.d_mem_we = is_st && (i == w);
        exp_q.push_back(e);
      end
    end
    e = '0; e.st = 3'd5; e.pc_we = 1'b1;
    e.pc_src = is_jal ? 2'd2 : (taken ? 2'd1 : 2'd0);
    e.rf_we  = is_r || is_i || is_ld || is_jal;
    e.rf_src = is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
    exp_q.push_back(e);
  endtask

  // Called at a negative edge; abort_at >= 0 pulls reset right after that trace cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [3:0] flags, input int abort_at);
    opcode = op; funct3 = f3; funct7b5 = f7; alu_flags = flags;
    build(sel ? 2 : 0, op, f3, f7, flags, 12);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s w%0d c%0d", name, sel ? 2 : 0, k), 32'(obs), 32'(exp_q[k]));
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check($sformatf("%s abort", name), 32'(obs), 32'd0);
        return;
      end
    end
  endtask

  task automatic do_reset(input int which);
    rst_n = 1'b0;
    sel = which;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("reset w%0d c%0d", which ? 2 : 0, k), 32'(obs), 32'd0);
    end
    rst_n = 1'b1;
    #1 check("idle", 32'(obs), 32'd0);
  endtask

  localparam logic [6:0] LEGAL_OPS [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                           7'b0100011, 7'b1100011, 7'b1101111};

  initial begin
    do_reset(0);
    run_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 4'd0, -1);
    run_instr("r_and", 7'b0110011, 3'b111, 1'b0, 4'd0, -1);
    run_instr("i_slt", 7'b0010011, 3'b010, 1'b1, 4'd0, -1);
    run_instr("i_add", 7'b0010011, 3'b000, 1'b1, 4'd0, -1);
    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 4'b0001, -1);
    run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 4'b0000, -1);
    run_instr("bne_t", 7'b1100011, 3'b001, 1'b0, 4'b0000, -1);
    run_instr("bne_n", 7'b1100011, 3'b001, 1'b0, 4'b1111, -1);
    run_instr("b_oth", 7'b1100011, 3'b100, 1'b0, 4'b0001, -1);
    run_instr("jal",   7'b1101111, 3'b011, 1'b0, 4'd0, -1);
    run_instr("load0", 7'b0000011, 3'b010, 1'b0, 4'd0, -1);
    run_instr("store0", 7'b0100011, 3'b010, 1'b0, 4'd0, -1);
    run_instr("ill0",  7'b1110011, 3'b000, 1'b0, 4'd0, -1);

    do_reset(1);
    run_instr("load2",  7'b0000011, 3'b010, 1'b0, 4'd0, -1);
    run_instr("store2", 7'b0100011, 3'b010, 1'b0, 4'd0, -1);
    run_instr("r_xor2", 7'b0110011, 3'b100, 1'b1, 4'd0, -1);
    run_instr("beq2",   7'b1100011, 3'b000, 1'b0, 4'b0001, -1);
    run_instr("st_abt", 7'b0100011, 3'b010, 1'b0, 4'd0, 6);
    @(posedge clk); @(negedge clk);
    check("abort_hold", 32'(obs), 32'd0);

    for (int blk = 0; blk < 2; blk++) begin
      do_reset(blk);
      for (int n = 0; n < 40; n++) begin
        run_instr($sformatf("rnd%0d", n), LEGAL_OPS[$urandom_range(0, 5)],
                  3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), -1);
      end
      run_instr("rnd_ill", 7'b1111111, 3'($urandom_range(0, 7)), 1'b0, 4'd0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
